fish_position_tracker: RTL and testbench
========================================

// Module: fish_position_tracker
// PURPOSE
// Consumes the per-tick step magnitudes (hm/vm) from the fish movement-tick stage and
// integrates them into an on-screen fish position. Runs spawn/swim/hooked/gone life cycle,
// flags edge escape and landing at the surface, and tells the VGA pixel path whether the
// current (h,v) pixel lies on the fish sprite, with the sprite ROM address.
// PARAMETERS
// SCR_W    640  visible width, pixels
// SCR_H    480  visible height, pixels
// FISH_W   32   sprite width, pixels
// FISH_H   16   sprite height, pixels
// Y_TOP    120  water-surface row; a hooked fish reaching it is landed
// PORTS
// clk      in   1   system clock
// rst      in   1   async reset, active-LOW (asserted when 0)
// hm       in   3   horizontal step magnitude; nonzero for one cycle = move tick
// vm       in   3   vertical sink-drift magnitude, sampled on the same tick
// way      in   2   0 swim left, 1 swim right, 2 hooked (rise), 3 hold
// appear   in   1   1 = fish should exist
// spawn_x  in   10  x loaded on spawn
// spawn_y  in   10  y loaded on spawn
// h, v     in   10  current VGA pixel coordinates
// fish_x   out  10  sprite top-left x
// fish_y   out  10  sprite top-left y
// alive    out  1   1 in SWIM or HOOK
// escaped  out  1   one-cycle pulse: fish left the screen horizontally
// landed   out  1   one-cycle pulse: hooked fish reached Y_TOP
// fish_on  out  1   registered: (h,v) inside sprite box and alive
// pix_addr out  9   registered: (v-fish_y)*FISH_W + (h-fish_x); 0 when fish_on=0
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; fish_x=0, fish_y=0, all 1-bit outputs 0, pix_addr=0.
// - tick = (hm != 0). All position math in 11-bit unsigned; no silent wrap of 10-bit regs.
// - IDLE: alive=0. appear=1 -> load fish_x=min(spawn_x,SCR_W-FISH_W),
//   fish_y=clamp(spawn_y,Y_TOP+1,SCR_H-FISH_H); enter SWIM next cycle. Ticks ignored.
// - SWIM (way 0/1) on tick: x -= hm (way 0) or x += hm (way 1); y += vm, clamped to
//   SCR_H-FISH_H. way 2 -> HOOK (applies from that tick on). way 3: hold position.
//   Left edge: hm > fish_x -> escaped pulse, fish_x=0, -> GONE.
//   Right edge: fish_x+hm > SCR_W-FISH_W -> escaped pulse, fish_x=SCR_W-FISH_W, -> GONE.
// - HOOK on tick: fish_y -= hm; x unchanged; vm ignored. If fish_y-hm <= Y_TOP ->
//   fish_y=Y_TOP, landed pulse, -> GONE. way 0/1 while hooked is ignored (no unhooking).
// - GONE: alive=0, position frozen; appear=0 -> IDLE. No respawn while appear stays 1.
// - appear=0 in SWIM/HOOK: -> IDLE next cycle, no escaped/landed pulse.
// - Simultaneous: edge crossing and appear=0 same cycle -> pulse fires, then GONE->IDLE.
// - escaped/landed never both high; each high exactly one cycle per event.
// - fish_on/pix_addr: 1-cycle latency from h,v; computed from fish_x/fish_y/alive of the
//   same cycle h,v are sampled. Box is half-open: [x,x+FISH_W) x [y,y+FISH_H).
// - Reset mid-swim clears immediately (async); pulses in flight are dropped.
// CONFIGURATION
// FISH_WRAP_EN defined: horizontal edges wrap instead of escaping: left crossing ->
//   fish_x = SCR_W-FISH_W, right crossing -> fish_x = 0; state stays SWIM; escaped never
//   asserts. Vertical/hook behaviour unchanged.
// FISH_WRAP_EN undefined: edge behaviour as above (escaped pulse, GONE).
// TESTING
// 1 rst=0 mid-SWIM at x=300 -> all outputs 0, state IDLE within same cycle; release -> stay IDLE until appear.
// 2 appear=1, spawn=(700,10) -> next cycle fish_x=608, fish_y=121, alive=1.
// 3 x=100,y=200, way=1, 10 ticks hm=4 vm=1 -> fish_x=140, fish_y=210; no pulses.
// 4 x=3, way=0, tick hm=5 -> escaped=1 one cycle, fish_x=0, alive=0; with FISH_WRAP_EN -> fish_x=608, alive=1, escaped=0.
// 5 y=125, way=2, tick hm=4 -> fish_y=121; next tick hm=4 -> fish_y=120, landed=1 one cycle, GONE; appear=0 -> IDLE.
// 6 fish at (100,200): h=100,v=200 -> next cycle fish_on=1, pix_addr=0; h=131,v=215 -> 511; h=132 -> fish_on=0, pix_addr=0.

Source files
------------

// File: rtl/fish_position_tracker.sv
// fish_position_tracker: integrates per-tick fish steps into a sprite position and runs its life cycle
//   Optional feature: define FISH_WRAP_EN to wrap at the horizontal edges instead of escaping.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     hm, vm            horizontal step / vertical sink drift (hm != 0 marks a move tick)
//     way               0 left, 1 right, 2 hooked (rise), 3 hold
//     appear            fish should exist
//     spawn_x, spawn_y  position loaded on spawn
//     h, v              current VGA pixel
//     fish_x, fish_y    sprite top-left corner
//     alive             fish is swimming or hooked
//     escaped, landed   one-cycle event pulses
//     fish_on, pix_addr registered sprite hit and sprite ROM address for (h,v)
module fish_position_tracker #(
   parameter int SCR_W  = 640,
   parameter int SCR_H  = 480,
   parameter int FISH_W = 32,
   parameter int FISH_H = 16,
   parameter int Y_TOP  = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] hm,
   input  logic [2:0] vm,
   input  logic [1:0] way,
   input  logic       appear,
   input  logic [9:0] spawn_x,
   input  logic [9:0] spawn_y,
   input  logic [9:0] h,
   input  logic [9:0] v,
   output logic [9:0] fish_x,
   output logic [9:0] fish_y,
   output logic       alive,
   output logic       escaped,
   output logic       landed,
   output logic       fish_on,
   output logic [8:0] pix_addr
);
   typedef enum logic [1:0] {IDLE, SWIM, HOOK, GONE} state_t;
   localparam logic [10:0] X_MAX = 11'(SCR_W - FISH_W);
   localparam logic [10:0] Y_MAX = 11'(SCR_H - FISH_H);
   localparam logic [10:0] Y_MIN = 11'(Y_TOP + 1);
   localparam logic [10:0] Y_SRF = 11'(Y_TOP);
   localparam logic [10:0] FW    = 11'(FISH_W);
   localparam logic [10:0] FH    = 11'(FISH_H);
`ifdef FISH_WRAP_EN
   localparam logic WRAP = 1'b1;
`else
   localparam logic WRAP = 1'b0;
`endif
   state_t state, state_n;
   logic [10:0] x11, y11, h11, v11, hm11, vm11, sx11, sy11, x_add, y_dn, dx, dy, x_n, y_n;
   logic tick, hooked, edge_l, edge_r, esc, land, move, in_box;
   assign x11   = {1'b0, fish_x};
   assign y11   = {1'b0, fish_y};
   assign h11   = {1'b0, h};
   assign v11   = {1'b0, v};
   assign sx11  = {1'b0, spawn_x};
   assign sy11  = {1'b0, spawn_y};
   assign hm11  = {8'd0, hm};
   assign vm11  = {8'd0, vm};
   assign tick  = hm != 3'd0;
   assign x_add = x11 + hm11;
   assign y_dn  = y11 + vm11;
   assign dx    = h11 - x11;
   assign dy    = v11 - y11;
   // way 2 seen while swimming already moves the fish as hooked on that same tick
   assign hooked = state == HOOK || (state == SWIM && way == 2'd2);
   assign edge_l = state == SWIM && tick && way == 2'd0 && hm11 > x11;
   assign edge_r = state == SWIM && tick && way == 2'd1 && x_add > X_MAX;
   assign esc    = !WRAP && (edge_l || edge_r);
   assign land   = hooked && tick && y11 <= Y_SRF + hm11;
   // an edge or landing event still completes when appear drops in the same cycle
   assign move   = (state == SWIM || state == HOOK) && tick && (appear || esc || land);
   assign in_box = alive && h11 >= x11 && h11 < x11 + FW && v11 >= y11 && v11 < y11 + FH;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = appear ? SWIM : IDLE;
         SWIM:    state_n = (esc || land) ? GONE : !appear ? IDLE : hooked ? HOOK : SWIM;
         HOOK:    state_n = land ? GONE : !appear ? IDLE : HOOK;
         default: state_n = appear ? GONE : IDLE;
      endcase
   end
   always_comb alive = state == SWIM || state == HOOK;
   always_comb begin
      x_n = x11;
      y_n = y11;
      if (state == IDLE && appear) begin
         x_n = sx11 > X_MAX ? X_MAX : sx11;
         y_n = sy11 < Y_MIN ? Y_MIN : sy11 > Y_MAX ? Y_MAX : sy11;
      end else if (move && hooked) begin
         y_n = land ? Y_SRF : y11 - hm11;
      end else if (move && way != 2'd3) begin
         x_n = way == 2'd0 ? (edge_l ? (WRAP ? X_MAX : 11'd0) : x11 - hm11)
                           : (edge_r ? (WRAP ? 11'd0 : X_MAX) : x_add);
         y_n = y_dn > Y_MAX ? Y_MAX : y_dn;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         fish_x   <= '0;
         fish_y   <= '0;
         escaped  <= 1'b0;
         landed   <= 1'b0;
         fish_on  <= 1'b0;
         pix_addr <= '0;
      end else begin
         fish_x   <= x_n[9:0];
         fish_y   <= y_n[9:0];
         escaped  <= esc;
         landed   <= land;
         fish_on  <= in_box;
         pix_addr <= in_box ? 9'(dy * FW + dx) : 9'd0;
      end
endmodule

// File: tb/tb_fish_position_tracker.sv
// tb_fish_position_tracker: directed checks of spawn, swim, edges, hooking and sprite hit
module tb_fish_position_tracker;
`ifdef FISH_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] hm = '0, vm = '0;
   logic [1:0] way = '0;
   logic       appear = 1'b0;
   logic [9:0] spawn_x = '0, spawn_y = '0, h = '0, v = '0;
   logic [9:0] fish_x, fish_y;
   logic       alive, escaped, landed, fish_on;
   logic [8:0] pix_addr;
   int         n_chk = 0, n_fail = 0;
   logic       pulses;
   fish_position_tracker dut (
      .clk(clk), .rst(rst), .hm(hm), .vm(vm), .way(way), .appear(appear),
      .spawn_x(spawn_x), .spawn_y(spawn_y), .h(h), .v(v),
      .fish_x(fish_x), .fish_y(fish_y), .alive(alive), .escaped(escaped),
      .landed(landed), .fish_on(fish_on), .pix_addr(pix_addr)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic tick(input logic [2:0] a, input logic [2:0] b);
      hm = a;
      vm = b;
      cyc(1);
      hm = '0;
      vm = '0;
   endtask
   task automatic spawn(input logic [9:0] x, input logic [9:0] y);
      spawn_x = x;
      spawn_y = y;
      appear  = 1'b1;
      cyc(1);
   endtask
   task automatic despawn();
      appear = 1'b0;
      cyc(1);
   endtask
   initial begin
      cyc(2);
      check("rst_x", fish_x, 0);
      check("rst_y", fish_y, 0);
      check("rst_alive", alive, 0);
      check("rst_esc", escaped, 0);
      check("rst_land", landed, 0);
      check("rst_on", fish_on, 0);
      check("rst_pix", pix_addr, 0);
      rst = 1'b1;
      way = 2'd3;
      spawn(300, 200);
      check("t1_x_before", fish_x, 300);
      check("t1_alive_before", alive, 1);
      #2 rst = 1'b0;
      #1;
      check("t1_async_x", fish_x, 0);
      check("t1_async_y", fish_y, 0);
      check("t1_async_alive", alive, 0);
      appear = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(3);
      check("t1_idle_alive", alive, 0);
      check("t1_idle_x", fish_x, 0);
      spawn(700, 10);
      check("t2_x", fish_x, 608);
      check("t2_y", fish_y, 121);
      check("t2_alive", alive, 1);
      despawn();
      check("t2_idle", alive, 0);
      way = 2'd1;
      spawn(100, 200);
      pulses = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(4, 1);
         pulses = pulses | escaped | landed;
      end
      check("t3_x", fish_x, 140);
      check("t3_y", fish_y, 210);
      check("t3_nopulse", pulses, 0);
      check("t3_alive", alive, 1);
      despawn();
      spawn(600, 460);
      tick(7, 7);
      tick(1, 0);
      check("rb_x_edge", fish_x, 608);
      check("rb_y_clamp", fish_y, 464);
      check("rb_noesc", escaped, 0);
      tick(1, 0);
      check("rb_esc", escaped, WRAP ? 0 : 1);
      check("rb_x", fish_x, WRAP ? 0 : 608);
      check("rb_alive", alive, WRAP ? 1 : 0);
      cyc(1);
      check("rb_esc_drop", escaped, 0);
      despawn();
      way = 2'd0;
      spawn(3, 200);
      tick(5, 0);
      check("t4_esc", escaped, WRAP ? 0 : 1);
      check("t4_x", fish_x, WRAP ? 608 : 0);
      check("t4_alive", alive, WRAP ? 1 : 0);
      cyc(1);
      check("t4_esc_drop", escaped, 0);
      despawn();
      spawn(3, 200);
      appear = 1'b0;
      tick(5, 0);
      check("sim_esc", escaped, WRAP ? 0 : 1);
      check("sim_alive", alive, 0);
      cyc(1);
      check("sim_esc_drop", escaped, 0);
      check("sim_idle_alive", alive, 0);
      spawn(50, 300);
      check("sim_respawn", alive, 1);
      despawn();
      way = 2'd2;
      spawn(100, 125);
      tick(4, 3);
      check("t5_y1", fish_y, 121);
      check("t5_alive1", alive, 1);
      check("t5_noland", landed, 0);
      way = 2'd0;
      tick(4, 0);
      check("t5_y2", fish_y, 120);
      check("t5_x", fish_x, 100);
      check("t5_land", landed, 1);
      check("t5_noesc", escaped, 0);
      check("t5_gone", alive, 0);
      cyc(1);
      check("t5_land_drop", landed, 0);
      cyc(3);
      check("t5_no_respawn", alive, 0);
      despawn();
      spawn(100, 125);
      check("t5_respawn", alive, 1);
      despawn();
      way = 2'd3;
      spawn(100, 200);
      tick(5, 2);
      check("hold_x", fish_x, 100);
      check("hold_y", fish_y, 200);
      h = 100;
      v = 200;
      cyc(1);
      check("t6_on_tl", fish_on, 1);
      check("t6_pix_tl", pix_addr, 0);
      h = 131;
      v = 215;
      cyc(1);
      check("t6_on_br", fish_on, 1);
      check("t6_pix_br", pix_addr, 511);
      h = 132;
      cyc(1);
      check("t6_on_right", fish_on, 0);
      check("t6_pix_right", pix_addr, 0);
      h = 105;
      v = 216;
      cyc(1);
      check("t6_on_below", fish_on, 0);
      h = 99;
      v = 203;
      cyc(1);
      check("t6_on_left", fish_on, 0);
      h = 110;
      v = 203;
      cyc(1);
      check("t6_pix_mid", pix_addr, 106);
      despawn();
      cyc(1);
      check("t6_on_dead", fish_on, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
